// File: rtl/midi_tx.sv
// -----------------------------------------------------------------------------
// midi_tx
//   MIDI transmit path. One note-on/note-off event is accepted per valid/ready
//   handshake. It is encoded as a channel message (status, note, velocity) and
//   shifted out as UART 8N1 on txData_o. Running status can drop the status byte
//   when it repeats the status byte that was last sent.
//
// Ports
//   clk_i        in   1  system clock, rising edge
//   nrst_i       in   1  asynchronous active-low reset
//   evtValid_i   in   1  event request, held by upstream until accepted
//   evtReady_o   out  1  block can accept an event (high only while idle)
//   evtNoteOn_i  in   1  1: note-on (0x9n), 0: note-off (0x8n)
//   ch_i         in   4  MIDI channel
//   note_i       in   7  note number
//   vel_i        in   7  velocity
//   txData_o     out  1  serial line, idle high, driven from a flop
//   busy_o       out  1  frame in progress, always !evtReady_o
// -----------------------------------------------------------------------------
module midi_tx #(
    parameter int CLK_FREQ       = 12_000_000,
    parameter int BAUD           = 31_250,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       evtValid_i,
    output logic       evtReady_o,
    input  logic       evtNoteOn_i,
    input  logic [3:0] ch_i,
    input  logic [6:0] note_i,
    input  logic [6:0] vel_i,
    output logic       txData_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Control state (reset)
    state_t           state;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitIdx;
    logic [1:0]       byteIdx;
    logic             lastStatusVld;
    logic             evtReady;
    logic             txData;

    // Datapath registers (no reset: always loaded before use)
    logic [7:0] lastStatus;
    logic [6:0] noteReg;
    logic [6:0] velReg;
    logic [7:0] shiftReg;

    logic [7:0] newStatus;
    logic       accept;
    logic       skipStatus;
    logic       bitEnd;

    // Data byte 1 is the note, byte 2 the velocity; byte 0 (status) is only
    // ever loaded straight from the inputs at acceptance.
    function automatic logic [7:0] dataByte(input logic [1:0] idx,
                                            input logic [6:0] n,
                                            input logic [6:0] v);
        return (idx == 2'd2) ? {1'b0, v} : {1'b0, n};
    endfunction

    assign newStatus  = {1'b1, 2'b00, evtNoteOn_i, ch_i};
    assign accept     = evtValid_i && evtReady;
    assign skipStatus = RUNNING_STATUS && lastStatusVld && (lastStatus == newStatus);
    assign bitEnd     = (baudCnt == CNT_LAST);

    assign evtReady_o = evtReady;
    assign busy_o     = !evtReady;
    assign txData_o   = txData;

    // Control FSM: every transition happens on the last clock of a bit, so each
    // bit lasts exactly CLKS_PER_BIT clocks and bytes follow back-to-back.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state         <= IDLE;
            baudCnt       <= '0;
            bitIdx        <= '0;
            byteIdx       <= '0;
            lastStatusVld <= 1'b0;
            evtReady      <= 1'b1;
            txData        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= START;
                        txData        <= 1'b0;
                        evtReady      <= 1'b0;
                        baudCnt       <= '0;
                        bitIdx        <= '0;
                        // Running status starts directly at the note byte.
                        byteIdx       <= skipStatus ? 2'd1 : 2'd0;
                        lastStatusVld <= 1'b1;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        state   <= DATA;
                        bitIdx  <= '0;
                        txData  <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state  <= STOP;
                            txData <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            txData <= shiftReg[0];
                        end
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        if (byteIdx == 2'd2) begin
                            state    <= IDLE;
                            evtReady <= 1'b1;
                        end else begin
                            byteIdx <= byteIdx + 2'd1;
                            state   <= START;
                            txData  <= 1'b0;
                        end
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: latch the event at acceptance, then shift LSB first. The shift
    // register always holds the next bit to put on the line in bit 0.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lastStatus <= newStatus;
            noteReg    <= note_i;
            velReg     <= vel_i;
            shiftReg   <= skipStatus ? {1'b0, note_i} : newStatus;
        end else if (state == STOP && bitEnd && byteIdx != 2'd2) begin
            shiftReg <= dataByte(byteIdx + 2'd1, noteReg, velReg);
        end else if ((state == START || state == DATA) && bitEnd) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// -----------------------------------------------------------------------------
// tb_midi_tx
//   Scoreboard bench for midi_tx. Stimulus pushes hand-computed line bytes and
//   decoded note events into queues; a monitor deserialises txData at mid-bit,
//   checks 8N1 framing, pops and compares bytes, and re-parses the MIDI stream
//   (including running status) into note events.
//   A reduced clock (16 clocks per bit) keeps the run short; frame lengths are
//   checked as 10 * nBytes * CPB.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_tx;

    localparam int CLK_FREQ = 500_000;
    localparam int BAUD     = 31_250;
    localparam int CPB      = CLK_FREQ / BAUD;   // 16

    logic       clk       = 1'b0;
    logic       nrst      = 1'b1;
    logic       evtValid  = 1'b0;
    logic       evtNoteOn = 1'b0;
    logic [3:0] ch        = 4'd0;
    logic [6:0] note      = 7'd0;
    logic [6:0] vel       = 7'd0;
    logic       evtReady;
    logic       txData;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acceptCyc = 0;

    logic [7:0]  expByteQ[$];
    logic [18:0] expEvtQ[$];   // {noteOn, ch, note, vel}

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .RUNNING_STATUS(1'b1)
    ) dut (
        .clk_i(clk),
        .nrst_i(nrst),
        .evtValid_i(evtValid),
        .evtReady_o(evtReady),
        .evtNoteOn_i(evtNoteOn),
        .ch_i(ch),
        .note_i(note),
        .vel_i(vel),
        .txData_o(txData),
        .busy_o(busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: UART receiver plus MIDI parser.
    initial begin : monitor
        int pos;
        int k;
        bit active;
        bit haveD1;
        logic [7:0] sh;
        logic [7:0] runStat;
        logic [6:0] d1;
        logic [18:0] ev;
        pos = 0; k = 0; active = 0; haveD1 = 0; sh = '0; runStat = '0; d1 = '0; ev = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                active  = 0;
                haveD1  = 0;
                runStat = '0;
            end else if (!active) begin
                if (txData === 1'b0) begin
                    active = 1;
                    pos    = 0;
                end
            end else begin
                pos++;
            end
            if (active && nrst && (pos % CPB == CPB / 2)) begin
                k = pos / CPB;
                if (k == 0) begin
                    check("startBit", {31'd0, txData}, 32'd0);
                end else if (k <= 8) begin
                    sh = {txData, sh[7:1]};
                end else begin
                    check("stopBit", {31'd0, txData}, 32'd1);
                    active = 0;
                    if (expByteQ.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpectedByte: got 0x%0h expected none", sh);
                    end else begin
                        check("lineByte", {24'd0, sh}, {24'd0, expByteQ.pop_front()});
                    end
                    if (sh[7]) begin
                        runStat = sh;
                        haveD1  = 0;
                    end else if (!haveD1) begin
                        d1     = sh[6:0];
                        haveD1 = 1;
                    end else begin
                        haveD1 = 0;
                        ev = {runStat[7:4] == 4'h9, runStat[3:0], d1, sh[6:0]};
                        if (expEvtQ.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpectedEvent: got 0x%0h expected none", ev);
                        end else begin
                            check("decodedEvent", {13'd0, ev}, {13'd0, expEvtQ.pop_front()});
                        end
                    end
                end
            end
        end
    end

    // Present an event, wait (bounded) for acceptance, push expectations.
    task automatic issue(input bit on, input logic [3:0] c, input logic [6:0] n,
                         input logic [6:0] v, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int guard;
        @(negedge clk);
        evtNoteOn = on; ch = c; note = n; vel = v; evtValid = 1'b1;
        guard = 0;
        while (evtReady !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (evtReady !== 1'b1) begin
            check("acceptTimeout", {31'd0, evtReady}, 32'd1);
            evtValid = 1'b0;
            return;
        end
        expByteQ.push_back(b0);
        expByteQ.push_back(b1);
        if (nb == 3) expByteQ.push_back(b2);
        expEvtQ.push_back({on, c, n, v});
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        evtValid = 1'b0;
        check("startLatency", {31'd0, txData}, 32'd0);
        check("readyLowAfterAccept", {31'd0, evtReady}, 32'd0);
        check("busyAfterAccept", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for ready to return and check the frame length.
    task automatic waitIdle(input int nb);
        int guard;
        guard = 0;
        while (evtReady !== 1'b1 && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("frameLen", cyc - acceptCyc, 10 * nb * CPB);
        check("busyIdle", {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lows;
        #2 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("resetTx", {31'd0, txData}, 32'd1);
        check("resetReady", {31'd0, evtReady}, 32'd1);
        check("resetBusy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: full note-on message
        issue(1'b1, 4'd0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64);
        waitIdle(3);

        // 2: running status drops the repeated 0x90, note-off re-sends status
        issue(1'b1, 4'd0, 7'd62, 7'd100, 2, 8'h3E, 8'h64, 8'h00);
        waitIdle(2);
        issue(1'b0, 4'd0, 7'd60, 7'd0, 3, 8'h80, 8'h3C, 8'h00);
        waitIdle(3);

        // 3: input churn and valid toggling while busy must not disturb the frame
        issue(1'b1, 4'd1, 7'd64, 7'd80, 3, 8'h91, 8'h40, 8'h50);
        for (int i = 0; i < 4; i++) begin
            repeat (5 * CPB) @(negedge clk);
            ch = ch + 4'd3;
            note = note + 7'd5;
            evtValid = ~evtValid;
            check("readyLowMidFrame", {31'd0, evtReady}, 32'd0);
            check("busyMidFrame", {31'd0, busy}, 32'd1);
        end
        waitIdle(3);
        lows = 0;
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (txData !== 1'b1) lows++;
        end
        check("noSecondFrame", lows, 0);

        // 4: reset in data bit 3 of the note byte (0x34, bit 3 = 0)
        issue(1'b1, 4'd0, 7'd52, 7'd100, 3, 8'h90, 8'h34, 8'h64);
        repeat (14 * CPB + CPB / 2) @(posedge clk);
        #3;
        check("noteBit3", {31'd0, txData}, 32'd0);
        nrst = 1'b0;
        expByteQ.delete();
        expEvtQ.delete();
        #1;
        check("asyncResetTx", {31'd0, txData}, 32'd1);
        check("asyncResetReady", {31'd0, evtReady}, 32'd1);
        check("asyncResetBusy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b1, 4'd0, 7'd52, 7'd100, 3, 8'h90, 8'h34, 8'h64);
        waitIdle(3);

        // 5: loopback decode of note-on / note-off on channel 5
        issue(1'b1, 4'd5, 7'd69, 7'd100, 3, 8'h95, 8'h45, 8'h64);
        waitIdle(3);
        issue(1'b0, 4'd5, 7'd69, 7'd64, 3, 8'h85, 8'h45, 8'h40);
        waitIdle(3);

        repeat (2 * CPB) @(negedge clk);
        check("bytesOutstanding", expByteQ.size(), 0);
        check("eventsOutstanding", expEvtQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
